// File: rtl/vericade_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vericade_pkg
//  Description : Shared constants and types for the Vericade button front end.
//                Button index map, channel count and the auto-repeat FSM
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package vericade_pkg;

    // Button index map into btn_raw / btn_pulse / btn_level
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_SEL   = 4;

    localparam int NUM_BTNS  = 5;

    // Auto-repeat state machine
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

endpackage : vericade_pkg
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// ============================================================================
//  Module      : btn_channel
//  Description : One push-button conditioning lane: 2-FF synchronizer,
//                integrating debouncer and press/auto-repeat strobe FSM.
//  Ports       : clk        - system clock
//                rst_n      - asynchronous active-low reset
//                i_btn_raw  - raw pin level, asynchronous to clk
//                i_enable   - strobe enable; low forces the FSM to IDLE
//                o_pulse    - registered one-cycle press/repeat strobe
//                o_level    - registered debounced level
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_channel #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_raw,
    input  logic i_enable,
    output logic o_pulse,
    output logic o_level
);
    import vericade_pkg::*;

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  c_db_term    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] c_delay_term = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] c_per_term   = RPT_W'(REPEAT_PERIOD - 1);

    // ------------------------------------------------------------------
    // Synchronizer + debouncer
    // ------------------------------------------------------------------
    logic            r_ff1;
    logic            r_sync;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_level;

    logic w_db_term;
    logic w_rise;
    logic w_fall;

    // The accepting edge doubles as the rising/falling-edge event, so the
    // press strobe is registered on the same clock as the new level.
    assign w_db_term = (r_sync != r_level) && (r_db_cnt == c_db_term);
    assign w_rise    = w_db_term &&  r_sync;
    assign w_fall    = w_db_term && !r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff1    <= 1'b0;
            r_sync   <= 1'b0;
            r_db_cnt <= '0;
            r_level  <= 1'b0;
        end else begin
            r_ff1  <= i_btn_raw;
            r_sync <= r_ff1;
            if (r_sync == r_level) begin
                // agreement (or a glitch back) discards partial integration
                r_db_cnt <= '0;
            end else if (w_db_term) begin
                r_level  <= r_sync;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Press / auto-repeat FSM
    // ------------------------------------------------------------------
    rpt_state_t       r_state;
    rpt_state_t       w_state_nxt;
    logic [RPT_W-1:0] r_rpt_cnt;
    logic [RPT_W-1:0] w_rpt_cnt_nxt;
    logic             r_pulse;
    logic             w_pulse_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rpt_cnt <= '0;
            r_pulse   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rpt_cnt <= w_rpt_cnt_nxt;
            r_pulse   <= w_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rpt_cnt_nxt = '0;
        w_pulse_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                // A rise seen while disabled is simply dropped here.
                if (w_rise && i_enable) begin
                    w_pulse_nxt = 1'b1;
                    if (REPEAT_EN) begin
                        w_state_nxt = DELAY;
                    end
                end
            end
            DELAY: begin
                // Release/disable wins over a coincident terminal count.
                if (w_fall || !i_enable) begin
                    w_state_nxt = IDLE;
                end else if (r_rpt_cnt == c_delay_term) begin
                    w_pulse_nxt = 1'b1;
                    w_state_nxt = REPEAT;
                end else begin
                    w_rpt_cnt_nxt = r_rpt_cnt + RPT_W'(1);
                end
            end
            REPEAT: begin
                if (w_fall || !i_enable) begin
                    w_state_nxt = IDLE;
                end else if (r_rpt_cnt == c_per_term) begin
                    w_pulse_nxt = 1'b1;
                end else begin
                    w_rpt_cnt_nxt = r_rpt_cnt + RPT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_pulse = r_pulse;
    assign o_level = r_level;

endmodule : btn_channel
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : btn_conditioner
//  Description : Five-lane push-button front end. Each lane synchronizes,
//                debounces and strobes one raw button; lanes selected by
//                REPEAT_MASK auto-repeat while held.
//  Ports       : clk       - system clock
//                rst_n     - asynchronous active-low reset
//                btn_raw   - raw active-high pin levels (async)
//                enable    - strobe enable (debounce keeps tracking when low)
//                btn_pulse - one-cycle press/repeat strobes, registered
//                btn_level - debounced stable levels, registered
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_conditioner
    import vericade_pkg::*;
#(
    parameter int                  DEBOUNCE_CYCLES = 1_000_000,
    parameter int                  REPEAT_DELAY    = 25_000_000,
    parameter int                  REPEAT_PERIOD   = 5_000_000,
    parameter logic [NUM_BTNS-1:0] REPEAT_MASK     = 5'b01100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BTNS-1:0] btn_raw,
    input  logic                enable,
    output logic [NUM_BTNS-1:0] btn_pulse,
    output logic [NUM_BTNS-1:0] btn_level
);

    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[gi])
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_btn_raw (btn_raw[gi]),
            .i_enable  (enable),
            .o_pulse   (btn_pulse[gi]),
            .o_level   (btn_level[gi])
        );
    end

endmodule : btn_conditioner
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_conditioner
//  Description : Directed self-checking bench for btn_conditioner with
//                DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
//                Vector r is driven before clock edge r and outputs are
//                sampled 1 ns after that edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_btn_conditioner;
    import vericade_pkg::*;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int LAT = DB + 1;        // raw edge -> level/pulse, in edges

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] btn_raw = '0;
    logic       enable  = 1'b0;
    logic [4:0] btn_pulse;
    logic [4:0] btn_level;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [4:0] raw;
        logic       en;
        logic [4:0] pulse;
        logic [4:0] level;
    } vec_t;

    localparam int NA = 28;            // clean press on Select
    localparam int NB = 25;            // bounce on Left
    vec_t tbl[NA+NB];

    btn_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_MASK     (5'b01100)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .enable    (enable),
        .btn_pulse (btn_pulse),
        .btn_level (btn_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx,
                         input logic [4:0] act, input logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic cycle(input logic [4:0] raw, input logic en);
        btn_raw = raw;
        enable  = en;
        @(posedge clk);
        #1;
    endtask

    // Hold Right for 'hold' cycles. Pulses at t0=LAT, t0+RD, t0+RD+k*RP,
    // only while the debounced level is still high (fall at hold+LAT).
    task automatic run_repeat(input string name, input int hold);
        for (int r = 0; r < hold + 10; r++) begin
            logic [4:0] ep;
            logic [4:0] el;
            cycle((r < hold) ? 5'b01000 : 5'b00000, 1'b1);
            el = (r >= LAT && r < hold + LAT) ? 5'b01000 : 5'b00000;
            ep = (r == LAT ||
                  (r >= LAT + RD && ((r - LAT - RD) % RP) == 0 && r < hold + LAT))
                 ? 5'b01000 : 5'b00000;
            check({name, "_pulse"}, r, btn_pulse, ep);
            check({name, "_level"}, r, btn_level, el);
        end
    endtask

    initial begin
        // ---------------- stimulus table ----------------
        for (int r = 0; r < NA; r++) begin
            tbl[r].raw   = (r < 20) ? 5'b10000 : 5'b00000;
            tbl[r].en    = 1'b1;
            tbl[r].pulse = (r == 5) ? 5'b10000 : 5'b00000;
            tbl[r].level = (r >= 5 && r < 25) ? 5'b10000 : 5'b00000;
        end
        // Left bounces 1,1,1,0,1,1,1,0 then holds from r=8 to r=16.
        // Accepted at r=13; release at r=17 falls at r=22, before the
        // first repeat would have landed at r=23.
        for (int r = 0; r < NB; r++) begin
            logic b;
            b = (r < 8) ? (r != 3 && r != 7) : (r < 17);
            tbl[NA+r].raw   = {2'b00, b, 2'b00};
            tbl[NA+r].en    = 1'b1;
            tbl[NA+r].pulse = (r == 13) ? 5'b00100 : 5'b00000;
            tbl[NA+r].level = (r >= 13 && r < 22) ? 5'b00100 : 5'b00000;
        end

        // ---------------- reset ----------------
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pulse", 0, btn_pulse, 5'b00000);
        check("rst_level", 0, btn_level, 5'b00000);
        rst_n = 1'b1;

        // ---------------- table-driven: clean press + bounce ----------------
        for (int i = 0; i < NA + NB; i++) begin
            cycle(tbl[i].raw, tbl[i].en);
            check((i < NA) ? "tbl_sel_pulse" : "tbl_bounce_pulse", i, btn_pulse, tbl[i].pulse);
            check((i < NA) ? "tbl_sel_level" : "tbl_bounce_level", i, btn_level, tbl[i].level);
        end

        // ---------------- auto-repeat ----------------
        run_repeat("repeat30", 30);           // last pulse t0+28, fall before next
        run_repeat("repeat_boundary", 31);    // fall lands on terminal count

        // ---------------- enable gating + simultaneous presses ----------------
        for (int r = 0; r < 10; r++) begin
            cycle(5'b10100, 1'b0);
            check("dis_pulse", r, btn_pulse, 5'b00000);
            check("dis_level", r, btn_level, (r >= LAT) ? 5'b10100 : 5'b00000);
        end
        for (int r = 0; r < 15; r++) begin
            cycle(5'b10100, 1'b1);
            check("en_held_pulse", r, btn_pulse, 5'b00000);
            check("en_held_level", r, btn_level, 5'b10100);
        end
        for (int r = 0; r < 8; r++) begin
            cycle(5'b00000, 1'b1);
            check("rel_pulse", r, btn_pulse, 5'b00000);
            check("rel_level", r, btn_level, (r < LAT) ? 5'b10100 : 5'b00000);
        end
        for (int r = 0; r < 15; r++) begin
            cycle((r < 8) ? 5'b10100 : 5'b00000, 1'b1);
            check("dual_pulse", r, btn_pulse, (r == LAT) ? 5'b10100 : 5'b00000);
            check("dual_level", r, btn_level,
                  (r >= LAT && r < 8 + LAT) ? 5'b10100 : 5'b00000);
        end

        // ---------------- async reset mid-repeat ----------------
        for (int r = 0; r <= 18; r++) begin
            cycle(5'b00100, 1'b1);
            check("pre_rst_pulse", r, btn_pulse,
                  (r == 5 || r == 15 || r == 18) ? 5'b00100 : 5'b00000);
            check("pre_rst_level", r, btn_level, (r >= LAT) ? 5'b00100 : 5'b00000);
        end
        #3;
        rst_n = 1'b0;                        // between edges, right after a pulse
        #1;
        check("async_rst_pulse", 0, btn_pulse, 5'b00000);
        check("async_rst_level", 0, btn_level, 5'b00000);
        @(posedge clk);
        #1;
        check("in_rst_level", 1, btn_level, 5'b00000);
        rst_n = 1'b1;
        for (int r = 0; r <= 16; r++) begin
            cycle(5'b00100, 1'b1);
            check("post_rst_pulse", r, btn_pulse,
                  (r == LAT || r == LAT + RD) ? 5'b00100 : 5'b00000);
            check("post_rst_level", r, btn_level, (r >= LAT) ? 5'b00100 : 5'b00000);
        end
        for (int r = 0; r < 8; r++) begin
            cycle(5'b00000, 1'b1);
        end
        check("final_level", 0, btn_level, 5'b00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_btn_conditioner
`default_nettype wire
